// File: rtl/onchip_mem_stream_reader.sv
// onchip_mem_stream_reader
// Reads a burst of consecutive words from an on-chip memory port (read
// latency 1) and emits them on an Avalon-ST source through a 2-entry FIFO.
// Reads are issued only while a FIFO slot is guaranteed for the returning
// word, so backpressure can never overflow the FIFO.
module onchip_mem_stream_reader #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W:0]       word_count,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     mem_address,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata,
    output logic [DATA_W-1:0]     src_data,
    output logic                  src_valid,
    output logic                  src_sop,
    output logic                  src_eop,
    input  logic                  src_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     remaining_q, remaining_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                first_q, first_d;
    // Tags of the read issued last cycle, whose data arrives this cycle
    logic                inflight_q, inflight_d;
    logic                infl_sop_q, infl_sop_d;
    logic                infl_eop_q, infl_eop_d;
    // Output FIFO, entry 0 is the head
    logic [DATA_W-1:0]   fifo_data_q [2];
    logic [DATA_W-1:0]   fifo_data_d [2];
    logic [1:0]          fifo_sop_q, fifo_sop_d;
    logic [1:0]          fifo_eop_q, fifo_eop_d;
    logic [1:0]          fifo_cnt_q, fifo_cnt_d;

    logic                pop_s;
    logic                issue_s;
    logic [2:0]          occ_s;
    logic [1:0]          wr_idx_s;

    // Handshake, credit and read-issue decision for the current cycle
    always_comb begin
        pop_s   = (fifo_cnt_q != 2'd0) & src_ready;
        // Words that will occupy the FIFO next cycle before this cycle's issue
        occ_s   = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop_s};
        issue_s = (state_q == RUN) && (remaining_q != {(ADDR_W+1){1'b0}})
                  && (occ_s < 3'd2);
    end

    // Burst control: next state, address/count bookkeeping, busy/done
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        first_d     = first_q;
        inflight_d  = issue_s;
        infl_sop_d  = issue_s & first_q;
        infl_eop_d  = issue_s & (remaining_q == {{ADDR_W{1'b0}}, 1'b1});
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (word_count != {(ADDR_W+1){1'b0}}) begin
                        state_d     = RUN;
                        addr_d      = base_addr;
                        remaining_d = word_count;
                        busy_d      = 1'b1;
                        first_d     = 1'b1;
                    end else begin
                        // Empty burst: complete immediately, never touch memory
                        done_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (issue_s) begin
                    addr_d      = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    remaining_d = remaining_q - {{ADDR_W{1'b0}}, 1'b1};
                    first_d     = 1'b0;
                    if (remaining_q == {{ADDR_W{1'b0}}, 1'b1}) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (pop_s && fifo_eop_q[0]) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Output FIFO: shift on pop, capture returning read data behind the head
    always_comb begin
        fifo_data_d[0] = fifo_data_q[0];
        fifo_data_d[1] = fifo_data_q[1];
        fifo_sop_d     = fifo_sop_q;
        fifo_eop_d     = fifo_eop_q;
        wr_idx_s       = fifo_cnt_q - {1'b0, pop_s};
        fifo_cnt_d     = fifo_cnt_q - {1'b0, pop_s} + {1'b0, inflight_q};
        if (pop_s) begin
            fifo_data_d[0] = fifo_data_q[1];
            fifo_sop_d[0]  = fifo_sop_q[1];
            fifo_eop_d[0]  = fifo_eop_q[1];
        end else begin
            fifo_data_d[0] = fifo_data_q[0];
        end
        if (inflight_q) begin
            if (wr_idx_s == 2'd0) begin
                fifo_data_d[0] = mem_readdata;
                fifo_sop_d[0]  = infl_sop_q;
                fifo_eop_d[0]  = infl_eop_q;
            end else begin
                fifo_data_d[1] = mem_readdata;
                fifo_sop_d[1]  = infl_sop_q;
                fifo_eop_d[1]  = infl_eop_q;
            end
        end else begin
            fifo_cnt_d = fifo_cnt_q - {1'b0, pop_s};
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            addr_q         <= {ADDR_W{1'b0}};
            remaining_q    <= {(ADDR_W+1){1'b0}};
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            first_q        <= 1'b0;
            inflight_q     <= 1'b0;
            infl_sop_q     <= 1'b0;
            infl_eop_q     <= 1'b0;
            fifo_data_q[0] <= {DATA_W{1'b0}};
            fifo_data_q[1] <= {DATA_W{1'b0}};
            fifo_sop_q     <= 2'b00;
            fifo_eop_q     <= 2'b00;
            fifo_cnt_q     <= 2'd0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            remaining_q    <= remaining_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            first_q        <= first_d;
            inflight_q     <= inflight_d;
            infl_sop_q     <= infl_sop_d;
            infl_eop_q     <= infl_eop_d;
            fifo_data_q[0] <= fifo_data_d[0];
            fifo_data_q[1] <= fifo_data_d[1];
            fifo_sop_q     <= fifo_sop_d;
            fifo_eop_q     <= fifo_eop_d;
            fifo_cnt_q     <= fifo_cnt_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    // Chipselect must react to this cycle's src_ready to sustain one word
    // per cycle, so it is decoded from registered state plus the handshake.
    assign mem_chipselect = issue_s;
    assign mem_address    = addr_q;
    assign mem_write      = 1'b0;
    assign mem_byteenable = {(DATA_W/8){1'b1}};
    assign mem_clken      = 1'b1;
    assign src_data       = fifo_data_q[0];
    assign src_valid      = (fifo_cnt_q != 2'd0);
    assign src_sop        = (fifo_cnt_q != 2'd0) & fifo_sop_q[0];
    assign src_eop        = (fifo_cnt_q != 2'd0) & fifo_eop_q[0];

endmodule
